// File: rtl/alu_flag_unit.sv
// Multi-cycle ALU with a persistent {N,Z,C,V} flag register, binary and
// nibble-serial BCD add/subtract, compare and pass, behind valid/ready handshakes.
module alu_flag_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic             decimal,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             flag_load,
  input  logic [3:0]       flag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam int NIB = WIDTH / 4;
  localparam int SW  = $clog2(NIB);

  localparam logic [1:0] OP_ADC  = 2'd0;
  localparam logic [1:0] OP_CMP  = 2'd2;
  localparam logic [1:0] OP_PASS = 2'd3;

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t           state_r, state_nxt_s;
  logic [1:0]       op_r;
  logic             dec_r, cin_r, dc_r;
  logic [WIDTH-1:0] a_r, b_r, sh_a_r, sh_b_r, result_r;
  logic [WIDTH-5:0] acc_r;
  logic [SW-1:0]    step_r;
  logic [3:0]       flags_r;

  logic             accept_s, last_s, cin_sel_s;
  logic [WIDTH-1:0] bin_b_s, dec_res_s, fin_res_s;
  logic [WIDTH:0]   bin_sum_s;
  logic             bin_ci_s, bin_v_s, fin_c_s, dcar_s;
  logic [4:0]       s5_s;
  logic [5:0]       d6_s;
  logic [3:0]       nib_s, fin_flags_s;

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign result    = result_r;
  assign flags     = flags_r;

  assign accept_s  = in_valid && (state_r == IDLE);
  // A flag load on the accept edge supplies the carry-in for that same op.
  assign cin_sel_s = flag_load ? flag_in[1] : flags_r[1];
  assign last_s    = !dec_r || (step_r == SW'(NIB - 1));

  // Binary datapath; SBC/CMP add the inverted subtrahend, so V is the add rule on bin_b_s.
  always_comb begin
    bin_b_s   = (op_r == OP_ADC) ? b_r : ~b_r;
    bin_ci_s  = (op_r == OP_CMP) ? 1'b1 : cin_r;
    bin_sum_s = {1'b0, a_r} + {1'b0, bin_b_s} + {{WIDTH{1'b0}}, bin_ci_s};
    bin_v_s   = (a_r[WIDTH-1] == bin_b_s[WIDTH-1]) && (bin_sum_s[WIDTH-1] != a_r[WIDTH-1]);
  end

  // One BCD nibble step; dc_r is carry for ADC and not-borrow for SBC.
  always_comb begin
    s5_s = {1'b0, sh_a_r[3:0]} + {1'b0, sh_b_r[3:0]} + {4'd0, dc_r};
    d6_s = {2'd0, sh_a_r[3:0]} - {2'd0, sh_b_r[3:0]} - {5'd0, ~dc_r};
    if (op_r == OP_ADC) begin
      if (s5_s > 5'd9) begin
        nib_s  = s5_s[3:0] + 4'd6;
        dcar_s = 1'b1;
      end else begin
        nib_s  = s5_s[3:0];
        dcar_s = 1'b0;
      end
    end else begin
      if (d6_s[5]) begin
        nib_s  = d6_s[3:0] - 4'd6;
        dcar_s = 1'b0;
      end else begin
        nib_s  = d6_s[3:0];
        dcar_s = 1'b1;
      end
    end
    dec_res_s = {nib_s, acc_r};
  end

  // Final result and flag update selection.
  always_comb begin
    fin_c_s = dec_r ? dcar_s : bin_sum_s[WIDTH];
    if (op_r == OP_PASS) begin
      fin_res_s = b_r;
    end else if (dec_r) begin
      fin_res_s = dec_res_s;
    end else begin
      fin_res_s = bin_sum_s[WIDTH-1:0];
    end
    fin_flags_s[3] = fin_res_s[WIDTH-1];
    fin_flags_s[2] = (fin_res_s == {WIDTH{1'b0}});
    fin_flags_s[1] = (op_r == OP_PASS) ? flags_r[1] : fin_c_s;
    fin_flags_s[0] = op_r[1] ? flags_r[0] : bin_v_s;
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    if (in_valid) state_nxt_s = CALC; else state_nxt_s = IDLE;
      CALC:    if (last_s) state_nxt_s = DONE; else state_nxt_s = CALC;
      DONE:    if (out_ready) state_nxt_s = IDLE; else state_nxt_s = DONE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_nxt_s;
  end

  // Operand latch, nibble sequencing, result and flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r     <= 2'd0;
      dec_r    <= 1'b0;
      cin_r    <= 1'b0;
      dc_r     <= 1'b0;
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      sh_a_r   <= {WIDTH{1'b0}};
      sh_b_r   <= {WIDTH{1'b0}};
      acc_r    <= {(WIDTH-4){1'b0}};
      step_r   <= {SW{1'b0}};
      result_r <= {WIDTH{1'b0}};
      flags_r  <= 4'd0;
    end else if (state_r == IDLE) begin
      if (flag_load) flags_r <= flag_in;
      if (accept_s) begin
        op_r   <= op;
        dec_r  <= decimal && !op[1];
        cin_r  <= cin_sel_s;
        dc_r   <= cin_sel_s;
        a_r    <= operand_a;
        b_r    <= operand_b;
        sh_a_r <= operand_a;
        sh_b_r <= operand_b;
        acc_r  <= {(WIDTH-4){1'b0}};
        step_r <= {SW{1'b0}};
      end
    end else if (state_r == CALC) begin
      if (last_s) begin
        result_r <= fin_res_s;
        flags_r  <= fin_flags_s;
      end else begin
        step_r <= step_r + SW'(1);
        sh_a_r <= {4'd0, sh_a_r[WIDTH-1:4]};
        sh_b_r <= {4'd0, sh_b_r[WIDTH-1:4]};
        acc_r  <= dec_res_s[WIDTH-1:4];
        dc_r   <= dcar_s;
      end
    end
  end

endmodule
